// File: rtl/bcd_chain_counter.sv
// Multi-digit BCD up/down counter with radix-limited load, whole-chain carry, terminal and sticky done flags.
// Optional match compare output is enabled by defining BCD_CHAIN_MATCH_EN.
module bcd_chain_counter #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_MAX = 9,
    parameter int WRAP      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  enable,
    input  logic                  up,
`ifdef BCD_CHAIN_MATCH_EN
    input  logic [4*DIGITS-1:0]   match_val,
`endif
    output logic [4*DIGITS-1:0]   q,
    output logic [DIGITS-1:0]     digit_ripple,
    output logic                  carry_out,
    output logic                  at_terminal,
    output logic                  done
`ifdef BCD_CHAIN_MATCH_EN
    ,
    output logic                  match
`endif
);

    localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

    logic [4*DIGITS-1:0] q_step;
    logic [DIGITS-1:0]   ripple_step;
    logic [4*DIGITS-1:0] load_clamped;
    logic                all_max;
    logic                all_zero;
    logic                held;

    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (q[4*i +: 4] != DMAX) all_max  = 1'b0;
            if (q[4*i +: 4] != 4'd0) all_zero = 1'b0;
        end
        at_terminal = up ? all_max : all_zero;
        // In halt mode a terminal step leaves the chain frozen.
        held = at_terminal && (WRAP == 0);
    end

    // Ripple-style step: each digit moves only while every lower digit sits at its wrap point.
    always_comb begin
        logic       step;
        logic [3:0] d;
        q_step      = q;
        ripple_step = '0;
        step        = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = q[4*i +: 4];
            if (step) begin
                if (up) begin
                    if (d == DMAX) begin
                        q_step[4*i +: 4] = 4'd0;
                        ripple_step[i]   = 1'b1;
                    end else begin
                        q_step[4*i +: 4] = d + 4'd1;
                    end
                end else begin
                    if (d == 4'd0) begin
                        q_step[4*i +: 4] = DMAX;
                        ripple_step[i]   = 1'b1;
                    end else begin
                        q_step[4*i +: 4] = d - 4'd1;
                    end
                end
            end
            step = step && (up ? (d == DMAX) : (d == 4'd0));
        end
    end

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = (load_val[4*i +: 4] > DMAX) ? DMAX : load_val[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q            <= '0;
            digit_ripple <= '0;
            carry_out    <= 1'b0;
            done         <= 1'b0;
        end else if (load) begin
            q            <= load_clamped;
            digit_ripple <= '0;
            carry_out    <= 1'b0;
            done         <= 1'b0;
        end else if (enable) begin
            if (held) begin
                digit_ripple <= '0;
                carry_out    <= 1'b0;
                done         <= 1'b1;
            end else begin
                q            <= q_step;
                digit_ripple <= ripple_step;
                carry_out    <= at_terminal;
                if (at_terminal) done <= 1'b1;
            end
        end else begin
            digit_ripple <= '0;
            carry_out    <= 1'b0;
        end
    end

`ifdef BCD_CHAIN_MATCH_EN
    // Fires only on a step that actually moves q, never on load, reset or a held terminal step.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            match <= 1'b0;
        end else if (enable && !held) begin
            match <= (q_step == match_val);
        end else begin
            match <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Bench for bcd_chain_counter: three parameterisations checked every cycle against an integer-valued model.
// Define BCD_CHAIN_MATCH_EN for both bench and RTL to also check the match output.
module tb_bcd_chain_counter;

    localparam int ND[3]  = '{4, 4, 2};
    localparam int RAD[3] = '{10, 10, 6};
    localparam int WR[3]  = '{1, 0, 1};

    logic        clk;
    logic        reset, load, enable, up;
    logic [15:0] load_val;
`ifdef BCD_CHAIN_MATCH_EN
    logic [15:0] match_val;
    logic        match0, match1, match2;
    logic        amatch[3];
    logic        mmatch[3];
`endif

    logic [15:0] q0, q1;
    logic [7:0]  q2;
    logic [3:0]  rip0, rip1;
    logic [1:0]  rip2;
    logic        car0, car1, car2, term0, term1, term2, done0, done1, done2;

    logic [15:0] aq[3];
    logic [3:0]  arip[3];
    logic        acar[3], aterm[3], adone[3];

    int          mval[3];
    logic [3:0]  mrip[3];
    logic        mcar[3], mdone[3];

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          check_on = 0;

    bcd_chain_counter #(.DIGITS(4), .DIGIT_MAX(9), .WRAP(1)) u0 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .enable(enable), .up(up),
`ifdef BCD_CHAIN_MATCH_EN
        .match_val(match_val), .match(match0),
`endif
        .q(q0), .digit_ripple(rip0), .carry_out(car0), .at_terminal(term0), .done(done0));

    bcd_chain_counter #(.DIGITS(4), .DIGIT_MAX(9), .WRAP(0)) u1 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .enable(enable), .up(up),
`ifdef BCD_CHAIN_MATCH_EN
        .match_val(match_val), .match(match1),
`endif
        .q(q1), .digit_ripple(rip1), .carry_out(car1), .at_terminal(term1), .done(done1));

    bcd_chain_counter #(.DIGITS(2), .DIGIT_MAX(5), .WRAP(1)) u2 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val[7:0]), .enable(enable), .up(up),
`ifdef BCD_CHAIN_MATCH_EN
        .match_val(match_val[7:0]), .match(match2),
`endif
        .q(q2), .digit_ripple(rip2), .carry_out(car2), .at_terminal(term2), .done(done2));

    assign aq[0] = q0;  assign aq[1] = q1;  assign aq[2] = {8'h00, q2};
    assign arip[0] = rip0; assign arip[1] = rip1; assign arip[2] = {2'b00, rip2};
    assign acar[0] = car0; assign acar[1] = car1; assign acar[2] = car2;
    assign aterm[0] = term0; assign aterm[1] = term1; assign aterm[2] = term2;
    assign adone[0] = done0; assign adone[1] = done1; assign adone[2] = done2;
`ifdef BCD_CHAIN_MATCH_EN
    assign amatch[0] = match0; assign amatch[1] = match1; assign amatch[2] = match2;
`endif

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ipow(int b, int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(int v, int r, int nd);
        logic [15:0] p = '0;
        int          x = v;
        for (int i = 0; i < nd; i++) begin
            p[4*i +: 4] = 4'(x % r);
            x = x / r;
        end
        return p;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the counter is an integer in radix R with D digits, modulo R^D.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            automatic int          r  = RAD[k];
            automatic int          n  = ipow(RAD[k], ND[k]);
            automatic logic [15:0] lv = (k == 2) ? {8'h00, load_val[7:0]} : load_val;
            automatic int          v  = 0;
            automatic logic [3:0]  rp = '0;
            automatic logic [3:0]  d;
            automatic bit          term;
            automatic int          m;
            if (reset) begin
                mval[k] <= 0; mrip[k] <= '0; mcar[k] <= 1'b0; mdone[k] <= 1'b0;
`ifdef BCD_CHAIN_MATCH_EN
                mmatch[k] <= 1'b0;
`endif
            end else if (load) begin
                for (int i = 0; i < ND[k]; i++) begin
                    d = lv[4*i +: 4];
                    v = v + ((int'(d) > r - 1) ? r - 1 : int'(d)) * ipow(r, i);
                end
                mval[k] <= v; mrip[k] <= '0; mcar[k] <= 1'b0; mdone[k] <= 1'b0;
`ifdef BCD_CHAIN_MATCH_EN
                mmatch[k] <= 1'b0;
`endif
            end else if (enable) begin
                term = up ? (mval[k] == n - 1) : (mval[k] == 0);
                if (term && WR[k] == 0) begin
                    mrip[k] <= '0; mcar[k] <= 1'b0; mdone[k] <= 1'b1;
`ifdef BCD_CHAIN_MATCH_EN
                    mmatch[k] <= 1'b0;
`endif
                end else begin
                    for (int i = 0; i < ND[k]; i++) begin
                        m = ipow(r, i + 1);
                        rp[i] = up ? (mval[k] % m == m - 1) : (mval[k] % m == 0);
                    end
                    v = up ? (mval[k] + 1) % n : (mval[k] + n - 1) % n;
                    mval[k] <= v; mrip[k] <= rp; mcar[k] <= term;
                    if (term) mdone[k] <= 1'b1;
`ifdef BCD_CHAIN_MATCH_EN
                    mmatch[k] <= (to_bcd(v, r, ND[k]) ==
                                  ((k == 2) ? {8'h00, match_val[7:0]} : match_val));
`endif
                end
            end else begin
                mrip[k] <= '0; mcar[k] <= 1'b0;
`ifdef BCD_CHAIN_MATCH_EN
                mmatch[k] <= 1'b0;
`endif
            end
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (check_on) begin
            for (int k = 0; k < 3; k++) begin
                automatic int n = ipow(RAD[k], ND[k]);
                check($sformatf("q[%0d]", k), 32'(aq[k]), 32'(to_bcd(mval[k], RAD[k], ND[k])));
                check($sformatf("ripple[%0d]", k), 32'(arip[k]), 32'(mrip[k]));
                check($sformatf("carry[%0d]", k), 32'(acar[k]), 32'(mcar[k]));
                check($sformatf("done[%0d]", k), 32'(adone[k]), 32'(mdone[k]));
                check($sformatf("at_terminal[%0d]", k), 32'(aterm[k]),
                      32'(up ? (mval[k] == n - 1) : (mval[k] == 0)));
`ifdef BCD_CHAIN_MATCH_EN
                check($sformatf("match[%0d]", k), 32'(amatch[k]), 32'(mmatch[k]));
`endif
            end
        end
    end

    // driver
    task automatic cyc(bit r, bit l, logic [15:0] lv, bit e, bit u);
        reset = r; load = l; load_val = lv; enable = e; up = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] lv;
        bit          r, l, e, u;
        reset = 1'b0; load = 1'b0; load_val = '0; enable = 1'b0; up = 1'b1;
`ifdef BCD_CHAIN_MATCH_EN
        match_val = 16'h0100;
`endif
        cyc(1, 0, 16'h0000, 0, 1);
        check_on = 1;
        check("reset_q", 32'(q0), 32'h0);
        check("reset_done", 32'(done0), 32'h0);
        check("reset_carry", 32'(car0), 32'h0);

        cyc(0, 1, 16'h0009, 0, 1);
        cyc(0, 0, 16'h0000, 1, 1);
        check("up_0009_q", 32'(q0), 32'h0010);
        check("up_0009_ripple", 32'(rip0), 32'h1);
        check("up_0009_carry", 32'(car0), 32'h0);

        cyc(0, 1, 16'h9999, 0, 1);
        cyc(0, 0, 16'h0000, 1, 1);
        check("wrap_q", 32'(q0), 32'h0000);
        check("wrap_ripple", 32'(rip0), 32'hf);
        check("wrap_carry", 32'(car0), 32'h1);
        check("wrap_done", 32'(done0), 32'h1);
        cyc(0, 0, 16'h0000, 0, 1);
        check("wrap_ripple_clear", 32'(rip0), 32'h0);
        check("wrap_carry_clear", 32'(car0), 32'h0);

        cyc(0, 1, 16'h0000, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0000, 1, 0);
        check("halt_q", 32'(q1), 32'h0000);
        check("halt_carry", 32'(car1), 32'h0);
        check("halt_done", 32'(done1), 32'h1);
        check("halt_at_terminal", 32'(term1), 32'h1);

        cyc(0, 1, 16'h7F3C, 0, 1);
        check("clamp_q4", 32'(q0), 32'h7939);
        check("clamp_q2", 32'(q2), 32'h35);
        cyc(1, 1, 16'h7F3C, 0, 1);
        check("reset_over_load", 32'(q0), 32'h0000);

        cyc(0, 1, 16'h0055, 0, 1);
        cyc(0, 0, 16'h0000, 1, 1);
        check("r6_wrap_q", 32'(q2), 32'h00);
        check("r6_wrap_carry", 32'(car2), 32'h1);
        cyc(0, 0, 16'h0000, 1, 1);
        check("r6_up_q", 32'(q2), 32'h01);
        cyc(0, 0, 16'h0000, 1, 0);
        check("r6_reverse_q", 32'(q2), 32'h00);
        check("r6_reverse_carry", 32'(car2), 32'h0);

`ifdef BCD_CHAIN_MATCH_EN
        cyc(0, 1, 16'h0098, 0, 1);
        cyc(0, 0, 16'h0000, 1, 1);
        check("match_early", 32'(match0), 32'h0);
        cyc(0, 0, 16'h0000, 1, 1);
        check("match_hit", 32'(match0), 32'h1);
        cyc(0, 0, 16'h0000, 0, 1);
        check("match_pulse_end", 32'(match0), 32'h0);
        cyc(0, 1, 16'h0100, 0, 1);
        check("match_on_load", 32'(match0), 32'h0);
`endif

        u = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0: lv = 16'h9999;
                1: lv = 16'h0000;
                2: lv = 16'h9998;
                3: lv = 16'h0001;
                4: lv = 16'h5554;
                default: lv = 16'($urandom);
            endcase
            e = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) u = ~u;
`ifdef BCD_CHAIN_MATCH_EN
            if ($urandom_range(0, 63) == 0) match_val = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'h9999;
`endif
            cyc(r, l, lv, e, u);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
